canvas_streamer: RTL

Upstream feeder for `neural_network`: on each inference trigger it walks the 28×28 drawing canvas produced by `canvas_editor` in row-major order. It presents one pixel per cycle on a valid/ready stream into the network's input layer. It sits between `canvas_editor` and `neural_network`, is clocked from `MAX10_CLK1_50`, and reports busy/done status so the top level can gate `Compute` and the HEX display.

---
 rtl/canvas_streamer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/canvas_streamer.sv
// Walks the DIM x DIM canvas in row-major order and streams one pixel per beat on a valid/ready port.
// Optional build macro CANVAS_STREAM_BINARIZE_EN thresholds each pixel against THRESH.
module canvas_streamer #(
  parameter int              DIM    = 28,
  parameter int              PIX_W  = 16,
  parameter logic [PIX_W-1:0] THRESH = 16'h8000
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  Start,
  input  logic [DIM-1:0][DIM-1:0][PIX_W-1:0]    canvas,
  output logic [PIX_W-1:0]                      Pix_Data,
  output logic                                  Pix_Valid,
  input  logic                                  Pix_Ready,
  output logic [9:0]                            Pix_Index,
  output logic                                  Pix_Last,
  output logic                                  Busy,
  output logic                                  Done,
  output logic                                  Overrun
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             start_q;
  logic [4:0]       row_q, row_d, col_q, col_d;
  logic [9:0]       idx_q, idx_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             valid_q, valid_d, last_q, last_d, ovr_q, ovr_d;
  logic             start_edge;

`ifdef CANVAS_STREAM_BINARIZE_EN
  function automatic logic [PIX_W-1:0] pix_f(input logic [PIX_W-1:0] v);
    return (v >= THRESH) ? {PIX_W{1'b1}} : '0;
  endfunction
`else
  localparam logic [PIX_W-1:0] thresh_unused = THRESH;
  function automatic logic [PIX_W-1:0] pix_f(input logic [PIX_W-1:0] v);
    return v;
  endfunction
`endif

  assign start_edge = Start & ~start_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: if (start_edge) begin
        state_d = S_LOAD;
        row_d   = '0;
        col_d   = '0;
        ovr_d   = 1'b0;
      end
      S_LOAD: begin
        data_d  = pix_f(canvas[0][0]);
        valid_d = 1'b1;
        idx_d   = '0;
        last_d  = 1'b0;
        state_d = S_STREAM;
      end
      S_STREAM: if (valid_q && Pix_Ready) begin
        if (last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          if (col_q == 5'(DIM-1)) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
          idx_d  = idx_q + 10'd1;
          // Next pixel is fetched on the accepting edge so beats are back to back.
          data_d = pix_f(canvas[row_d][col_d]);
          last_d = (row_d == 5'(DIM-1)) && (col_d == 5'(DIM-1));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && start_edge) ovr_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= Start;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Pix_Data  = data_q;
  assign Pix_Valid = valid_q;
  assign Pix_Index = idx_q;
  assign Pix_Last  = last_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Overrun   = ovr_q;

endmodule
